// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// State enum, opcode values, ALUOp classes and datapath mux encodings.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_MEMADR     = 4'd2,
    S_MEMREAD    = 4'd3,
    S_MEMWB      = 4'd4,
    S_MEMWRITE   = 4'd5,
    S_EXECR      = 4'd6,
    S_EXECI      = 4'd7,
    S_UPPER      = 4'd8,
    S_ALUWB      = 4'd9,
    S_BRANCH     = 4'd10,
    S_JAL        = 4'd11,
    S_EXECI_JALR = 4'd12,
    S_JALR_PC    = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALUOP_R      = 3'b000;
  localparam logic [2:0] ALUOP_BRANCH = 3'b001;
  localparam logic [2:0] ALUOP_ADD    = 3'b010;
  localparam logic [2:0] ALUOP_I      = 3'b011;
  localparam logic [2:0] ALUOP_UPPER  = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/branch_decide.sv
// Branch-taken decision from funct3 and the ALU zero flag.
// BNE/BLT/BLTU take the branch when the comparison result is nonzero.
module branch_decide
  import multicycle_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  output logic       taken
);

  logic invert;

  assign invert = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign taken  = zero ^ invert;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: sequences fetch through
// writeback and produces datapath enables, mux selects and the ALUOp class.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter bit SUPPORT_STALL = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       Illegal
);

  state_t state_reg;
  state_t state_next;
  logic   mem_ready;
  logic   branch_taken;
  logic   write_ok;

  assign mem_ready = SUPPORT_STALL ? MemReady : 1'b1;
  // Write strobes must stay quiet for the whole reset pulse, not just after the edge.
  assign write_ok  = ~RST;

  branch_decide u_branch_decide (
    .funct3 (funct3),
    .zero   (Zero),
    .taken  (branch_taken)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_I:              state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_EXECI_JALR;
          OP_LUI, OP_AUIPC:  state_next = S_UPPER;
          default:           state_next = S_FETCH;
        endcase
      end
      S_MEMADR:     state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:    if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:      state_next = S_FETCH;
      S_MEMWRITE:   if (mem_ready) state_next = S_FETCH;
      S_EXECR:      state_next = S_ALUWB;
      S_EXECI:      state_next = S_ALUWB;
      S_UPPER:      state_next = S_ALUWB;
      S_ALUWB:      state_next = S_FETCH;
      S_BRANCH:     state_next = S_FETCH;
      S_JAL:        state_next = S_ALUWB;
      S_EXECI_JALR: state_next = S_JALR_PC;
      S_JALR_PC:    state_next = S_ALUWB;
      default:      state_next = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_R;
    Illegal   = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALUOP_ADD;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready & write_ok;
        PCWrite   = mem_ready & write_ok;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
        case (opcode)
          OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH,
          OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: Illegal = 1'b0;
          default:                           Illegal = 1'b1;
        endcase
      end
      S_MEMADR, S_EXECI_JALR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = write_ok;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = write_ok;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_R;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_I;
      end
      S_UPPER: begin
        ALUSrcA = opcode[5] ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_UPPER;
      end
      S_ALUWB:    RegWrite = write_ok;
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_BRANCH;
        PCWrite = branch_taken & write_ok;
      end
      // JALR reuses the JAL step once rs1+imm has been latched into ALUOut.
      S_JAL, S_JALR_PC: begin
        PCWrite = write_ok;
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        ALUOp   = ALUOP_ADD;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed test of multicycle_control: per-cycle output vectors for each
// instruction class, stalls, branch decisions, illegal opcode and reset.
module tb_multicycle_control;

  logic       CLK;
  logic       RST;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUOp;

  int total = 0;
  int bad   = 0;

  multicycle_control #(.SUPPORT_STALL(1'b1)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .opcode    (opcode),
    .funct3    (funct3),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .Illegal   (Illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,Illegal}
  logic [14:0] outs;
  assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUOp, Illegal};

  localparam logic [14:0] V_FETCH     = {5'b10010, 2'b10, 2'b00, 2'b10, 3'b010, 1'b0};
  localparam logic [14:0] V_FETCH_NW  = {5'b00000, 2'b10, 2'b00, 2'b10, 3'b010, 1'b0};
  localparam logic [14:0] V_DECODE    = {5'b00000, 2'b00, 2'b01, 2'b01, 3'b010, 1'b0};
  localparam logic [14:0] V_DECODE_IL = {5'b00000, 2'b00, 2'b01, 2'b01, 3'b010, 1'b1};
  localparam logic [14:0] V_MEMADR    = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b010, 1'b0};
  localparam logic [14:0] V_MEMREAD   = {5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [14:0] V_MEMWB     = {5'b00001, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [14:0] V_MEMWRITE  = {5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [14:0] V_EXECR     = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0};
  localparam logic [14:0] V_EXECI     = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b011, 1'b0};
  localparam logic [14:0] V_LUI       = {5'b00000, 2'b00, 2'b11, 2'b01, 3'b100, 1'b0};
  localparam logic [14:0] V_AUIPC     = {5'b00000, 2'b00, 2'b01, 2'b01, 3'b100, 1'b0};
  localparam logic [14:0] V_ALUWB     = {5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [14:0] V_BR_TAKEN  = {5'b10000, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0};
  localparam logic [14:0] V_BR_NOT    = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0};
  localparam logic [14:0] V_JAL       = {5'b10000, 2'b00, 2'b01, 2'b10, 3'b010, 1'b0};
  localparam logic [14:0] V_JALR_ADR  = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b010, 1'b0};

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", tag, got, want);
    end else begin
      $display("ok   %s: %b", tag, got);
    end
  endtask

  // One clock cycle: apply MemReady, check the combinational outputs, advance.
  task automatic cyc(input string tag, input logic mr, input logic [14:0] want);
    MemReady = mr;
    #1;
    check(tag, outs, want);
    @(posedge CLK);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic z);
    opcode = op;
    funct3 = f3;
    Zero   = z;
  endtask

  initial begin
    RST = 1'b1; opcode = 7'd0; funct3 = 3'd0; Zero = 1'b0; MemReady = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    check("reset_fetch_gated", outs, V_FETCH_NW);
    RST = 1'b0;

    // R-type: 4 cycles, RegWrite only in the last
    set_instr(7'b0110011, 3'b000, 1'b0);
    cyc("r_fetch", 1'b1, V_FETCH);
    cyc("r_decode", 1'b1, V_DECODE);
    cyc("r_execr", 1'b1, V_EXECR);
    cyc("r_aluwb", 1'b1, V_ALUWB);

    // LW with three stall cycles in MEMREAD: 8 cycles
    set_instr(7'b0000011, 3'b010, 1'b0);
    cyc("lw_fetch", 1'b1, V_FETCH);
    cyc("lw_decode", 1'b1, V_DECODE);
    cyc("lw_memadr", 1'b1, V_MEMADR);
    for (int i = 0; i < 3; i++) cyc("lw_memread_stall", 1'b0, V_MEMREAD);
    cyc("lw_memread_done", 1'b1, V_MEMREAD);
    cyc("lw_memwb", 1'b1, V_MEMWB);

    // SW with one stall in MEMWRITE; MemWrite must drop in the next fetch
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("sw_fetch", 1'b1, V_FETCH);
    cyc("sw_decode", 1'b1, V_DECODE);
    cyc("sw_memadr", 1'b1, V_MEMADR);
    cyc("sw_memwrite_stall", 1'b0, V_MEMWRITE);
    cyc("sw_memwrite_done", 1'b1, V_MEMWRITE);

    // Fetch stall holds IRWrite/PCWrite low
    set_instr(7'b0010011, 3'b000, 1'b0);
    cyc("i_fetch_stall", 1'b0, V_FETCH_NW);
    cyc("i_fetch", 1'b1, V_FETCH);
    cyc("i_decode", 1'b1, V_DECODE);
    cyc("i_execi", 1'b1, V_EXECI);
    cyc("i_aluwb", 1'b1, V_ALUWB);

    // Branches: BNE Z=0 taken, BNE Z=1 not, BGE Z=1 taken, BEQ Z=0 not
    set_instr(7'b1100011, 3'b001, 1'b0);
    cyc("bne_fetch", 1'b1, V_FETCH);
    cyc("bne_decode", 1'b1, V_DECODE);
    cyc("bne_z0_taken", 1'b1, V_BR_TAKEN);
    set_instr(7'b1100011, 3'b001, 1'b1);
    cyc("bne2_fetch", 1'b1, V_FETCH);
    cyc("bne2_decode", 1'b1, V_DECODE);
    cyc("bne_z1_not", 1'b1, V_BR_NOT);
    set_instr(7'b1100011, 3'b101, 1'b1);
    cyc("bge_fetch", 1'b1, V_FETCH);
    cyc("bge_decode", 1'b1, V_DECODE);
    cyc("bge_z1_taken", 1'b1, V_BR_TAKEN);
    set_instr(7'b1100011, 3'b000, 1'b0);
    cyc("beq_fetch", 1'b1, V_FETCH);
    cyc("beq_decode", 1'b1, V_DECODE);
    cyc("beq_z0_not", 1'b1, V_BR_NOT);

    // LUI / AUIPC
    set_instr(7'b0110111, 3'b000, 1'b0);
    cyc("lui_fetch", 1'b1, V_FETCH);
    cyc("lui_decode", 1'b1, V_DECODE);
    cyc("lui_upper", 1'b1, V_LUI);
    cyc("lui_aluwb", 1'b1, V_ALUWB);
    set_instr(7'b0010111, 3'b000, 1'b0);
    cyc("auipc_fetch", 1'b1, V_FETCH);
    cyc("auipc_decode", 1'b1, V_DECODE);
    cyc("auipc_upper", 1'b1, V_AUIPC);
    cyc("auipc_aluwb", 1'b1, V_ALUWB);

    // JAL (4 cycles) and JALR (5 cycles)
    set_instr(7'b1101111, 3'b000, 1'b0);
    cyc("jal_fetch", 1'b1, V_FETCH);
    cyc("jal_decode", 1'b1, V_DECODE);
    cyc("jal_jal", 1'b1, V_JAL);
    cyc("jal_aluwb", 1'b1, V_ALUWB);
    set_instr(7'b1100111, 3'b000, 1'b0);
    cyc("jalr_fetch", 1'b1, V_FETCH);
    cyc("jalr_decode", 1'b1, V_DECODE);
    cyc("jalr_execi", 1'b1, V_JALR_ADR);
    cyc("jalr_pc", 1'b1, V_JAL);
    cyc("jalr_aluwb", 1'b1, V_ALUWB);

    // Illegal opcode: one-cycle pulse in DECODE, back to FETCH
    set_instr(7'b1111111, 3'b000, 1'b0);
    cyc("ill_fetch", 1'b1, V_FETCH);
    cyc("ill_decode", 1'b1, V_DECODE_IL);
    set_instr(7'b0110011, 3'b000, 1'b0);
    cyc("ill_back_fetch", 1'b1, V_FETCH);
    cyc("ill_next_decode", 1'b1, V_DECODE);
    cyc("ill_next_execr", 1'b1, V_EXECR);
    cyc("ill_next_aluwb", 1'b1, V_ALUWB);

    // Asynchronous reset in the middle of a stalled load
    set_instr(7'b0000011, 3'b010, 1'b0);
    cyc("rst_lw_fetch", 1'b1, V_FETCH);
    cyc("rst_lw_decode", 1'b1, V_DECODE);
    cyc("rst_lw_memadr", 1'b1, V_MEMADR);
    MemReady = 1'b0;
    #1;
    check("rst_lw_memread", outs, V_MEMREAD);
    RST = 1'b1;
    MemReady = 1'b1;
    #1;
    check("rst_async_fetch", outs, V_FETCH_NW);
    @(posedge CLK); #1;
    check("rst_held_gated", outs, V_FETCH_NW);
    RST = 1'b0;
    #1;
    check("rst_release_fetch", outs, V_FETCH);
    @(posedge CLK); #1;
    cyc("rst_first_decode", 1'b1, V_DECODE);
    cyc("rst_first_memadr", 1'b1, V_MEMADR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle RV32I core. It sits directly upstream of the ALU control decoder. Each state produces the datapath enables and mux selects, plus the 3-bit ALUOp class that the ALU control decoder combines with funct3/funct7[5] to select the ALU operation. It sequences fetch, decode, execute, memory and writeback, and stalls on a memory-ready handshake.

Parameters:
SUPPORT_STALL, 1, when 0 MemReady is ignored and treated as constant 1.

Ports:
CLK  in  1  core clock, rising edge
RST  in  1  asynchronous, active-high reset
opcode  in  7  instr[6:0] from the instruction register
funct3  in  3  instr[14:12], used only for the branch-taken decision
Zero  in  1  ALU result == 0
MemReady  in  1  memory completed the access this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
MemWrite  out  1  data memory write strobe
IRWrite  out  1  instruction register and OldPC enable
RegWrite  out  1  register file write enable
ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data register, 10 = ALUResult
ALUSrcA  out  2  ALU A: 00 = PC, 01 = OldPC, 10 = rs1 register, 11 = zero
ALUSrcB  out  2  ALU B: 00 = rs2 register, 01 = ImmExt, 10 = constant 4
ALUOp  out  3  000 = R-type, 001 = branch, 010 = load/store (ADD), 011 = I-type, 100 = LUI/AUIPC (ADD)
Illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode

Behaviour:
- Outputs are Moore-decoded from the state. Exceptions: PCWrite, IRWrite and MemWrite are additionally gated as stated below.
- Any output not listed for a state is 0.
- RST asserted at any time, including mid-instruction: state goes to FETCH immediately. While RST is high, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. The first fetch starts on the first rising edge after release.
- FETCH: AdrSrc=0, A=00, B=10, ALUOp=010, ResultSrc=10. IRWrite and PCWrite are asserted only when MemReady=1. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: A=01, B=01, ALUOp=010, so ALUOut = OldPC + imm (branch/JAL target). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> EXECI_JALR
  - 0110111 or 0010111 -> UPPER
  - anything else -> FETCH, with Illegal=1 for that cycle
- MEMADR: A=10, B=01, ALUOp=010. Goes to MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1. Waits for MemReady, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite held at 1 until MemReady=1, then FETCH. MemWrite is 0 in the following cycle.
- EXECR: A=10, B=00, ALUOp=000, then ALUWB.
- EXECI: A=10, B=01, ALUOp=011, then ALUWB.
- UPPER: B=01, ALUOp=100. A=11 for LUI (opcode[5]=1), A=01 for AUIPC. Then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: A=10, B=00, ALUOp=001, ResultSrc=00. PCWrite = Zero XOR (funct3 in {001, 100, 110}). This covers BEQ, BGE and BGEU taken on Zero; BNE, BLT and BLTU taken on !Zero. Then FETCH.
- JAL: ResultSrc=00, PCWrite=1, A=01, B=10, ALUOp=010 (ALUOut <= OldPC+4), then ALUWB.
- EXECI_JALR: A=10, B=01, ALUOp=010, then JALR_PC.
- JALR_PC: same outputs as JAL (PC <= ALUOut, ALUOut <= OldPC+4), then ALUWB.
- Cycles per instruction with MemReady=1: R/I/LUI/AUIPC/SW = 4, LW = 5, branch = 3, JAL = 4, JALR = 5.
- Each cycle of MemReady=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- No ALU_CONTROL-undefined class codes (101–111) are ever driven.

Decomposition:
- Package multicycle_pkg holds:
  - state_t enum (4-bit)
  - opcode localparams (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - ALUOp class constants
  - ALUSrcA/ALUSrcB/ResultSrc encodings
- One natural sub-module: branch_decide, which maps funct3 and Zero to the taken flag.
- The rest is a single next-state block plus an output-decode block.

Test Plan:
- RST=1 mid-MEMREAD, released -> next cycle state=FETCH; PCWrite, IRWrite, RegWrite and MemWrite stay 0 during reset; first fetch has ALUOp=010, B=10.
- opcode=0110011, MemReady=1 -> 4 cycles; EXECR drives ALUOp=000, A=10, B=00; RegWrite=1 only in cycle 4.
- opcode=0000011, MemReady low for 3 cycles in MEMREAD -> LW takes 8 cycles; RegWrite=1 with ResultSrc=01 in the last cycle.
- opcode=1100011, funct3=001 (BNE), Zero=0 -> PCWrite=1 in BRANCH with ALUOp=001; repeat with Zero=1 -> PCWrite=0; funct3=101 (BGE), Zero=1 -> PCWrite=1.
- opcode=0110111 (LUI) -> UPPER drives A=11, B=01, ALUOp=100; opcode=0010111 (AUIPC) -> A=01.
- opcode=1111111 -> Illegal pulses for 1 cycle in DECODE, then FETCH; no write enable asserted.
